// File: rtl/sm_pkg.sv
`default_nettype none
//==[ sm_pkg | rev 1.0 ]==========================================================
//  Shared types and default sizing for the sm_dispatch feeder.
package sm_pkg;

  typedef logic signed [15:0] x_t;
  typedef logic signed [31:0] y_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } dispatch_state_e;

  localparam int DEFAULT_DEPTH          = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage
`default_nettype wire

// File: rtl/sm_fifo.sv
`default_nettype none
//==[ sm_fifo | rev 1.0 ]=========================================================
//  Synchronous FIFO of x_t samples; an extra pointer bit separates full from empty.
module sm_fifo
  import sm_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  x_t   din,
  output x_t   dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  x_t          mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] wr_ptr_d;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    // A push while full is dropped, so push+pop at full never overwrites the head.
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm_dispatch.sv
`default_nettype none
//==[ sm_dispatch | rev 1.0 ]=====================================================
//  Queues x samples, runs one state_machine job at a time with a timeout, reports (x, y).
module sm_dispatch
  import sm_pkg::*;
#(
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_x,
  output logic               sm_start,
  output logic signed [15:0] sm_x,
  input  logic               sm_done,
  input  logic signed [31:0] sm_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_x,
  output logic signed [31:0] out_y,
  output logic               out_timeout,
  output logic               busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  dispatch_state_e state_q;
  dispatch_state_e state_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  x_t              sm_x_q;
  x_t              sm_x_d;
  x_t              out_x_q;
  x_t              out_x_d;
  y_t              out_y_q;
  y_t              out_y_d;
  logic            out_timeout_q;
  logic            out_timeout_d;
  logic            done_q;
  logic            done_d;
  logic            done_rise;

  logic            fifo_push;
  logic            fifo_pop;
  x_t              fifo_head;
  logic            fifo_full;
  logic            fifo_empty;

  assign fifo_push = in_valid && in_ready;

  sm_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_x),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A done level carried over from an earlier job is not a rise, so it never completes a new job.
  assign done_d    = sm_done;
  assign done_rise = sm_done && !done_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    sm_x_d        = sm_x_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    out_timeout_d = out_timeout_q;
    fifo_pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sm_x_d   = fifo_head;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (done_rise) begin
          out_y_d       = sm_y;
          out_x_d       = sm_x_q;
          out_timeout_d = 1'b0;
          state_d       = RESULT;
        end else if (timer_q == TIMER_LAST) begin
          out_y_d       = '0;
          out_x_d       = sm_x_q;
          out_timeout_d = 1'b1;
          state_d       = RESULT;
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      sm_x_q        <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_timeout_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      sm_x_q        <= sm_x_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      out_timeout_q <= out_timeout_d;
      done_q        <= done_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign sm_start    = (state_q == LAUNCH);
  assign sm_x        = sm_x_q;
  assign out_valid   = (state_q == RESULT);
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_timeout = out_timeout_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_sm_dispatch.sv
`default_nettype none
//==[ tb_sm_dispatch | rev 1.0 ]==================================================
//  Directed bench for sm_dispatch: stub core, queue-based reference model, per-cycle compare.
module tb_sm_dispatch;
  import sm_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_x;
  logic               sm_start;
  logic signed [15:0] sm_x;
  logic               sm_done;
  logic signed [31:0] sm_y;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_x;
  logic signed [31:0] out_y;
  logic               out_timeout;
  logic               busy;

  always #5 clk = ~clk;

  sm_dispatch #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .sm_start    (sm_start),
    .sm_x        (sm_x),
    .sm_done     (sm_done),
    .sm_y        (sm_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_timeout (out_timeout),
    .busy        (busy)
  );

  typedef struct { int lat; bit sticky; } cfg_t;
  typedef struct { int x; int y; bit to; } res_t;

  cfg_t cfg_q[$];     // per-job behaviour of the stub core, in launch order
  res_t exp_q[$];     // expected reports, in push order
  int   launch_q[$];  // samples accepted but not yet launched

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_start_cyc = -1;
  int last_push_cyc = 0;
  int n_starts = 0;
  bit in_job = 1'b0;
  int job_x = 0;
  bit prev_start = 1'b0;

  int cap_x, cap_y, cap_cyc;
  bit cap_to;

  // Stand-in for the state_machine core: reproduces its reference results for 10 and -8.
  function automatic int ref_core(int x);
    if (x == 10) return 38;
    if (x == -8) return -4;
    return 3 * x - 7;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Stub core: done rises lat cycles after start and stays high until the next start.
  // lat=0 never finishes; sticky keeps an old done level high through the new job.
  logic               st_busy = 1'b0;
  int                 st_cnt = 0;
  int                 st_lat = 0;
  logic signed [15:0] st_x = '0;
  logic               st_done = 1'b0;
  logic signed [31:0] st_y = '0;
  assign sm_done = st_done;
  assign sm_y    = st_y;

  initial forever begin
    @(posedge clk);
    if (sm_start) begin
      if (cfg_q.size() > 0) begin
        st_lat  <= cfg_q[0].lat;
        st_busy <= (cfg_q[0].lat != 0) && !cfg_q[0].sticky;
        if (!cfg_q[0].sticky) st_done <= 1'b0;
        void'(cfg_q.pop_front());
      end else begin
        st_lat  <= 1;
        st_busy <= 1'b1;
        st_done <= 1'b0;
      end
      st_x   <= sm_x;
      st_cnt <= 1;
    end else if (st_busy) begin
      if (st_cnt == st_lat) begin
        st_done <= 1'b1;
        st_y    <= ref_core(st_x);
        st_busy <= 1'b0;
      end else begin
        st_cnt <= st_cnt + 1;
      end
    end
  end

  // Per-cycle compare against the reference model.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      launch_q.delete();
      cfg_q.delete();
      in_job     = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (sm_start) begin
        n_starts++;
        last_start_cyc = cyc;
        chk("start_width", prev_start, 0);
        chk("start_overlap", in_job, 0);
        chk("start_has_job", launch_q.size() > 0, 1);
        if (launch_q.size() > 0) begin
          job_x  = launch_q.pop_front();
          in_job = 1'b1;
        end
      end
      if (in_job) chk("sm_x_hold", sm_x, job_x);
      chk("in_ready", in_ready, launch_q.size() < DEPTH);
      chk("busy", busy, in_job || (launch_q.size() > 0));
      if (out_valid) begin
        chk("out_valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("out_x", out_x, exp_q[0].x);
          chk("out_y", out_y, exp_q[0].y);
          chk("out_timeout", out_timeout, exp_q[0].to);
          if (out_ready) begin
            void'(exp_q.pop_front());
            in_job = 1'b0;
          end
        end
      end
      prev_start = sm_start;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(int x, int lat, bit sticky);
    bit ok = 1'b0;
    bit to;
    in_valid = 1'b1;
    in_x     = 16'(x);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("push_accepted", ok, 1);
    if (ok) begin
      last_push_cyc = cyc;
      to = sticky || (lat == 0) || (lat >= TMO);
      launch_q.push_back(x);
      cfg_q.push_back('{lat, sticky});
      exp_q.push_back('{x, (to ? 0 : ref_core(x)), to});
    end
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = out_valid;
      if (ok) begin
        cap_x   = out_x;
        cap_y   = out_y;
        cap_to  = out_timeout;
        cap_cyc = cyc;
      end
    end
    chk("wait_valid_bound", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = !busy && !out_valid && (exp_q.size() == 0);
    end
    chk("drain_bound", ok, 1);
  endtask

  task automatic chk_reset_outputs(string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_x"}, out_x, 0);
    chk({tag, "_out_y"}, out_y, 0);
    chk({tag, "_out_timeout"}, out_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_sm_start"}, sm_start, 0);
    chk({tag, "_sm_x"}, sm_x, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int n;
    bit ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Single job, latency 3.
    s0 = n_starts;
    push(10, 3, 1'b0);
    n = last_push_cyc;
    wait_valid();
    chk("t1_start_after_push", last_start_cyc - n, 2);
    chk("t1_valid_after_start", cap_cyc - last_start_cyc, 5);
    chk("t1_out_x", cap_x, 10);
    chk("t1_out_y", cap_y, 38);
    chk("t1_out_timeout", cap_to, 0);
    drain();
    chk("t1_starts", n_starts - s0, 1);

    // Back-to-back pushes.
    s0 = n_starts;
    push(-8, 2, 1'b0);
    push(10, 2, 1'b0);
    wait_valid();
    chk("t2_first_x", cap_x, -8);
    chk("t2_first_y", cap_y, -4);
    wait_valid();
    chk("t2_second_x", cap_x, 10);
    chk("t2_second_y", cap_y, 38);
    drain();
    chk("t2_starts", n_starts - s0, 2);

    // Back-pressure: one job in flight plus a full FIFO.
    s0 = n_starts;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(100 + i, 3, 1'b0);
    @(negedge clk);
    chk("t3_in_ready_full", in_ready, 0);
    chk("t3_busy", busy, 1);
    @(posedge clk);
    #1;
    wait_valid();
    chk("t3_first_x", cap_x, 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", out_valid, 1);
      chk("t3_stall_x", out_x, 100);
      chk("t3_stall_y", out_y, 293);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(105, 3, 1'b0);
    drain();
    chk("t3_starts", n_starts - s0, 6);

    // Timeout, then the queued job proceeds.
    push(1234, 0, 1'b0);
    push(-30000, 2, 1'b0);
    wait_valid();
    chk("t4_to_x", cap_x, 1234);
    chk("t4_to_y", cap_y, 0);
    chk("t4_to_flag", cap_to, 1);
    chk("t4_to_latency", cap_cyc - last_start_cyc, TMO + 1);
    wait_valid();
    chk("t4_next_x", cap_x, -30000);
    chk("t4_next_y", cap_y, -90007);
    chk("t4_next_flag", cap_to, 0);
    chk("t4_next_latency", cap_cyc - last_start_cyc, 4);
    drain();

    // Done on the last timeout cycle wins; one cycle later loses.
    push(500, TMO - 1, 1'b0);
    push(501, TMO, 1'b0);
    wait_valid();
    chk("t5_collide_flag", cap_to, 0);
    chk("t5_collide_y", cap_y, 1493);
    chk("t5_collide_latency", cap_cyc - last_start_cyc, TMO + 1);
    wait_valid();
    chk("t5_late_flag", cap_to, 1);
    chk("t5_late_y", cap_y, 0);
    drain();

    // Stale done level from the previous job must not complete the next one.
    push(600, 2, 1'b0);
    push(601, 0, 1'b1);
    push(602, 1, 1'b0);
    wait_valid();
    chk("t5_prev_y", cap_y, 1793);
    wait_valid();
    chk("t5_stale_x", cap_x, 601);
    chk("t5_stale_flag", cap_to, 1);
    chk("t5_stale_latency", cap_cyc - last_start_cyc, TMO + 1);
    wait_valid();
    chk("t5_after_y", cap_y, 1799);
    chk("t5_after_latency", cap_cyc - last_start_cyc, 3);
    drain();

    // Reset in the middle of WAIT with another sample queued.
    s0 = n_starts;
    push(77, 10, 1'b0);
    push(55, 2, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (n_starts != s0);
    end
    chk("t6_started", ok, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs("t6_reset");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("t6_no_late_valid", n, 0);
    chk("t6_idle_busy", busy, 0);
    chk("t6_no_restart", n_starts - s0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm_dispatch.md
Name: sm_dispatch

Overview:
- Upstream feeder for the `state_machine` compute core.
- Buffers incoming signed x samples in a small FIFO and launches one job at a time on the core's start/x_in/done interface.
- Captures y_out on completion and presents the (x, y) pair downstream on a valid/ready port.
- Adds a per-job timeout so a hung core cannot stall the pipeline.

Parameters:
- DEPTH, 4, input FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 64, max cycles in WAIT before the job is aborted; ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream sample valid
- in_ready  out  1  FIFO not full
- in_x  in  16  signed sample
- sm_start  out  1  one-cycle start pulse to core
- sm_x  out  16  signed operand to core, held stable for the whole job
- sm_done  in  1  core done (level)
- sm_y  in  32  signed core result
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_x  out  16  operand of the reported job
- out_y  out  32  result (0 on timeout)
- out_timeout  out  1  job aborted by timeout
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (sync, rst=1 at posedge): FIFO emptied, state=IDLE.
  - sm_start=0, sm_x=0, out_valid=0, out_x=0, out_y=0, out_timeout=0, busy=0, in_ready=1, done_q=0.
  - rst overrides everything, including mid-job. An in-flight core job is abandoned and its later done is ignored, because done_q is reset and the state is IDLE.
- FIFO:
  - Push when in_valid&&in_ready.
  - in_ready = !full.
  - Pointers are DEPTH-wrap with an extra bit for full/empty.
  - Simultaneous push and pop while full is not allowed (in_ready=0). Simultaneous push/pop otherwise keeps the count.
- done_q is sm_done registered every cycle. done_rise = sm_done && !done_q.
- States:
  - IDLE: if FIFO non-empty, pop head into sm_x and go to LAUNCH. Pop-to-start latency is 1 cycle.
  - LAUNCH: sm_start=1 for exactly this cycle. Clear timer. Go to WAIT.
  - WAIT:
    - Timer increments each cycle.
    - If done_rise: latch out_y=sm_y, out_x=sm_x, out_timeout=0, go to RESULT.
    - Else if timer==TIMEOUT_CYCLES-1: out_y=0, out_x=sm_x, out_timeout=1, go to RESULT.
    - done_rise wins over timeout on the same cycle.
  - RESULT: out_valid=1. Outputs are stable while out_valid&&!out_ready. On out_ready, go to IDLE (out_valid drops the next cycle).
- sm_x holds its value through WAIT and RESULT and changes only on a pop in IDLE.
- Throughput: at most one job per (core latency + 3) cycles. There is no overlap of jobs.
- A sm_done already high when entering WAIT, i.e. level left over from a prior job, is not a rise and is ignored.
- Widths:
  - out_y passes sm_y unchanged.
  - Sign is preserved end to end; no arithmetic is done here.

Decomposition:
- Package sm_pkg holds:
  - typedef x_t = logic signed [15:0]
  - typedef y_t = logic signed [31:0]
  - enum dispatch_state_e {IDLE, LAUNCH, WAIT, RESULT}
  - localparams for default DEPTH and TIMEOUT_CYCLES
- One natural sub-module: sm_fifo, a parameterised synchronous FIFO of x_t with push/pop/full/empty.
- FSM, timer and result registers stay in sm_dispatch.

Test Plan:
- Reset then single job: push x=10 with the real state_machine attached and out_ready=1.
  - Expect sm_start high exactly one cycle, 1 cycle after the pop.
  - Expect out_valid with out_x=10, out_y=38, out_timeout=0.
- Back-to-back: push -8 then 10 in consecutive cycles.
  - Results appear in order: (-8,-4) then (10,38).
  - sm_x is stable throughout each job.
  - Exactly two sm_start pulses.
- FIFO full/back-pressure: hold out_ready=0 and push DEPTH+2 samples.
  - in_ready drops after the FIFO plus the in-flight job fill.
  - No sample is lost or duplicated.
  - out_valid/out_x/out_y stay stable while stalled.
- Timeout: a stub core never asserts done.
  - After TIMEOUT_CYCLES in WAIT: out_valid=1, out_timeout=1, out_y=0, out_x equals the pushed value.
  - The next queued job then launches normally.
- Done/timeout collision and stale done:
  - Stub asserts done on the last timeout cycle -> out_timeout=0 and out_y equals sm_y.
  - Stub holding done high from the previous job does not complete the new job.
- Reset mid-WAIT: assert rst during a job.
  - All outputs return to reset values next cycle and the FIFO is empty.
  - A late sm_done produces no out_valid.
